// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, sequencer state encoding and stage-control patterns
package pipe_ctrl_pkg;

    localparam int REG_ID_W = 3;
    localparam int PERF_W   = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_GO       = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0};
    localparam ctrl_t CTRL_FREEZE   = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1,
                                        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b1};
    localparam ctrl_t CTRL_DRAIN    = '{pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, memwb_flush: 1'b0};
    localparam ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, memwb_flush: 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                        ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0, memwb_flush: 1'b0};
    localparam ctrl_t CTRL_FETCH    = '{pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                        ifid_flush: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0};
    localparam ctrl_t CTRL_STOP     = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
                                        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard/status inputs and stage enable/flush outputs of the pipeline sequencer
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ID_W-1:0] id_rs;
    logic [REG_ID_W-1:0] id_rt;
    logic                id_rs_valid;
    logic                id_rt_valid;
    logic [REG_ID_W-1:0] ex_write_reg;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                mem_redirect;
    logic                mem_access;
    logic                mem_halt;
    logic                dmem_done;
    logic                imem_stall;
    logic                pc_en;
    logic                ifid_en;
    logic                idex_en;
    logic                exmem_en;
    logic                memwb_en;
    logic                ifid_flush;
    logic                idex_flush;
    logic                exmem_flush;
    logic                memwb_flush;
    logic                dmem_req;
    logic                halted;
    logic                mem_timeout_err;
    logic [PERF_W-1:0]   perf_stall_cnt;
    logic [PERF_W-1:0]   perf_flush_cnt;

    modport master (
        input  id_rs, id_rt, id_rs_valid, id_rt_valid, ex_write_reg, ex_reg_write, ex_mem_read,
               mem_redirect, mem_access, mem_halt, dmem_done, imem_stall,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               dmem_req, halted, mem_timeout_err, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        output id_rs, id_rt, id_rs_valid, id_rt_valid, ex_write_reg, ex_reg_write, ex_mem_read,
               mem_redirect, mem_access, mem_halt, dmem_done, imem_stall,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               dmem_req, halted, mem_timeout_err, perf_stall_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_load_use_detect.sv
// load_use_detect: flags an ID-stage source that needs the result of a load still in EX
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ID_W-1:0] id_rs_i,
    input  logic [REG_ID_W-1:0] id_rt_i,
    input  logic                id_rs_valid_i,
    input  logic                id_rt_valid_i,
    input  logic [REG_ID_W-1:0] ex_write_reg_i,
    input  logic                ex_reg_write_i,
    input  logic                ex_mem_read_i,
    output logic                hazard_o
);

    assign hazard_o = ex_mem_read_i & ex_reg_write_i &
                      ((id_rs_valid_i & (id_rs_i == ex_write_reg_i)) |
                       (id_rt_valid_i & (id_rt_i == ex_write_reg_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the five-stage pipeline; PIPE_CTRL_PERF_EN builds the perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    pipe_ctrl_if.master bus
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [TW-1:0] TMAX  = TW'(MEM_TIMEOUT);
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          halted_q;
    logic          err_q;
    logic          hazard;
    logic          mem_stall;
    ctrl_t         c;

    load_use_detect u_load_use_detect (
        .id_rs_i        (bus.id_rs),
        .id_rt_i        (bus.id_rt),
        .id_rs_valid_i  (bus.id_rs_valid),
        .id_rt_valid_i  (bus.id_rt_valid),
        .ex_write_reg_i (bus.ex_write_reg),
        .ex_reg_write_i (bus.ex_reg_write),
        .ex_mem_read_i  (bus.ex_mem_read),
        .hazard_o       (hazard)
    );

    assign mem_stall = bus.mem_access & ~bus.dmem_done;

    // Priority-resolved stage controls and next state; tmo counts frozen cycles including the entry cycle
    always_comb begin
        c       = CTRL_GO;
        state_d = state_q;
        tmo_d   = '0;
        drain_d = '0;
        if (state_q == ST_RUN) begin
            if (mem_stall) begin
                c       = CTRL_FREEZE;
                state_d = ST_MEM_WAIT;
                tmo_d   = TW'(1);
            end else if (bus.mem_halt) begin
                c       = CTRL_DRAIN;
                state_d = ST_DRAIN;
            end else if (bus.mem_redirect) begin
                c = CTRL_REDIRECT;
            end else if (hazard) begin
                c = CTRL_LOAD_USE;
            end else if (bus.imem_stall) begin
                c = CTRL_FETCH;
            end
        end else if (state_q == ST_MEM_WAIT) begin
            c       = bus.dmem_done ? CTRL_GO : CTRL_FREEZE;
            state_d = bus.dmem_done ? ST_RUN : ST_MEM_WAIT;
            tmo_d   = bus.dmem_done ? '0 : (tmo_q == TMAX ? tmo_q : tmo_q + TW'(1));
        end else if (state_q == ST_DRAIN) begin
            c       = CTRL_DRAIN;
            state_d = (drain_q == DLAST) ? ST_HALTED : ST_DRAIN;
            drain_d = drain_q + DW'(1);
        end else begin
            c = CTRL_STOP;
        end
    end

    // Sequencer state, wait/drain counters, halted flag and sticky watchdog error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            tmo_q    <= '0;
            drain_q  <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == ST_HALTED);
            err_q    <= err_q | (tmo_d == TMAX);
        end
    end

    assign bus.pc_en           = c.pc_en;
    assign bus.ifid_en         = c.ifid_en;
    assign bus.idex_en         = c.idex_en;
    assign bus.exmem_en        = c.exmem_en;
    assign bus.memwb_en        = c.memwb_en;
    assign bus.ifid_flush      = c.ifid_flush;
    assign bus.idex_flush      = c.idex_flush;
    assign bus.exmem_flush     = c.exmem_flush;
    assign bus.memwb_flush     = c.memwb_flush;
    assign bus.dmem_req        = ((state_q == ST_RUN) & bus.mem_access) | (state_q == ST_MEM_WAIT);
    assign bus.halted          = halted_q;
    assign bus.mem_timeout_err = err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic              stall_ev;
    logic              redirect_ev;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    assign stall_ev    = ((state_q == ST_RUN) | (state_q == ST_MEM_WAIT)) & ~c.pc_en;
    assign redirect_ev = (state_q == ST_RUN) & ~mem_stall & ~bus.mem_halt & bus.mem_redirect;

    // Saturating stall-cycle and redirect counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_ev && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (redirect_ev && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 16-bit five-stage pipeline.
- Drives enable and flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Pipeline registers are plain reset-to-zero dffs with an enable/flush mux in front; flush loads all-zero, which is a NOP with every control bit 0.
- Resolves, in priority order: data-memory wait, halt drain, branch/jump redirect, load-use hazard, instruction-memory stall.

Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before mem_timeout_err is raised.
- DRAIN_CYCLES, 1: cycles spent in DRAIN before HALTED, letting the halting instruction reach WB.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_rs  in  3  Rs of instruction in ID
- id_rt  in  3  Rt of instruction in ID
- id_rs_valid  in  1  id_rs is a real source
- id_rt_valid  in  1  id_rt is a real source
- ex_write_reg  in  3  destination of instruction in EX (ID/EX out)
- ex_reg_write  in  1  EX instruction writes a register
- ex_mem_read  in  1  EX instruction is a load
- mem_redirect  in  1  EX/MEM stage: taken branch or jump
- mem_access  in  1  EX/MEM stage: mem_read or mem_write
- mem_halt  in  1  EX/MEM stage: halt
- dmem_done  in  1  data memory completes the current access
- imem_stall  in  1  instruction memory not ready this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (overrides enable)
- dmem_req  out  1  data access request
- halted  out  1  pipeline stopped
- mem_timeout_err  out  1  sticky watchdog error
- perf_stall_cnt  out  16  stall-cycle count
- perf_flush_cnt  out  16  redirect count

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Reset: state=RUN, timeout counter=0, drain counter=0, halted=0, mem_timeout_err=0, perf counters=0.
- Control outputs are combinational from state and inputs. The first post-reset cycle with quiet inputs gives all en=1, all flush=0, dmem_req=0.
- dmem_req = (RUN & mem_access) | MEM_WAIT.
- RUN, priority 1 (memory wait): mem_access & !dmem_done -> go to MEM_WAIT. Freeze pc/ifid/idex/exmem (en=0), memwb_flush=1. If dmem_done arrives in the same cycle, no stall.
- RUN, priority 2 (halt): mem_halt -> go to DRAIN. pc_en=0; ifid_flush, idex_flush, exmem_flush=1 (younger instructions discarded); memwb_en=1.
- RUN, priority 3 (redirect): mem_redirect -> pc_en=1 (PC loads target); ifid_flush, idex_flush, exmem_flush=1. If mem_halt is also set, halt wins.
- RUN, priority 4 (load-use): ex_mem_read & ex_reg_write & ((id_rs_valid & id_rs==ex_write_reg) | (id_rt_valid & id_rt==ex_write_reg)) -> pc_en=0, ifid_en=0, idex_flush=1. Applies only when no redirect.
- RUN, priority 5 (fetch stall): imem_stall -> pc_en=0, ifid_flush=1; later stages advance.
- MEM_WAIT: same freeze as the entry cycle; dmem_req=1; timeout counter increments each cycle.
  - On dmem_done -> RUN; that cycle all en=1 and memwb_flush=0; counter clears.
  - Counter reaching MEM_TIMEOUT sets mem_timeout_err (sticky until rst); state stays MEM_WAIT.
- DRAIN: pc_en=0; ifid/idex/exmem flush=1; memwb_en=1. Counts DRAIN_CYCLES cycles, then -> HALTED.
- HALTED: all en=0, flush=0, dmem_req=0, halted=1. Exit only via rst.
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN next cycle; no outstanding request is remembered.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN, when defined:
  - perf_stall_cnt is a 16-bit saturating (stops at 0xFFFF) count of cycles with pc_en=0 in RUN or MEM_WAIT.
  - perf_flush_cnt is a 16-bit saturating count of redirect cycles.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_DRAIN=2'd2, ST_HALTED=2'd3;
  - REG_ID_W=3;
  - PERF_W=16.
- One sub-module, load_use_detect: purely combinational register-ID compare. It takes id_rs/id_rt/valids and ex_write_reg/ex_reg_write/ex_mem_read, and outputs a hazard bit.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_write_reg=3'd2, id_rs=3'd2, id_rs_valid=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1. Repeat with id_rs_valid=0 -> no stall.
- Memory wait: mem_access=1 and dmem_done held low 3 cycles -> dmem_req=1 for 4 cycles, 3 frozen cycles with memwb_flush=1, state RUN in the cycle after done. With MEM_TIMEOUT=4 and done withheld, mem_timeout_err=1 on the 4th wait cycle.
- Redirect plus load-use in the same cycle: mem_redirect=1 -> ifid/idex/exmem flush=1, pc_en=1, no load-use stall.
- Halt: mem_halt=1 -> DRAIN for 1 cycle, then halted=1 and all en=0 held 10 cycles. rst=1 -> halted=0 the next cycle.
- Simultaneous mem_access (no done), mem_halt and imem_stall -> MEM_WAIT first; after dmem_done, the next cycle enters DRAIN.
- With PIPE_CTRL_PERF_EN: 5 load-use stalls plus 3 fetch stalls -> perf_stall_cnt=8; 2 redirects -> perf_flush_cnt=2. Without the macro both read 0.
